alarm_sched: RTL and testbench
==============================

# alarm_sched

Alarm ring/snooze sequencer for the digital clock. Watches the running BCD time and the stored alarm time, raises a ring request at the alarm minute, and sequences RING / SNOOZE / IDLE from the debounced snooze and stop keys. It drives the alarm LED and status flags, and sits beside the time/alarm counters and debouncers in the top level.

## Interface
Parameters:
- CLK_HZ, 50_000_000, clk frequency (documentation only).
- RING_SEC, 60, seconds a ring lasts before auto-stop.
- SNOOZE_MIN, 5, snooze length in minutes.
- MAX_SNOOZE, 3, snoozes allowed per alarm event (1..3).
- BLINK_CYC, 12_500_000, clk cycles per LED half-period while ringing.

Ports:
- clk  in  1  system clock.
- s_rst_n  in  1  reset, asynchronous, active-low.
- hour_h, hour_l, min_h, min_l, sec_h, sec_l  in  4 each  running time, BCD.
- alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l  in  4 each  alarm time, BCD.
- alarm_en  in  1  debounced alarm-enable switch.
- adjust  in  2  nonzero while time or alarm is being edited.
- key_snooze  in  1  one-cycle debounced key pulse.
- key_stop  in  1  one-cycle debounced key pulse.
- ring  out  1  high in RING.
- snoozing  out  1  high in SNOOZE.
- led  out  1  blinks in RING, 0 otherwise.
- snooze_cnt  out  2  snoozes used in current event.

## Operation
- match = (hour_h,hour_l,min_h,min_l equal alarm_*) && sec_h==0 && sec_l==0.
- match_d registers match, reset value 1. trig = match & ~match_d, so it fires once per alarm minute. A reset taken during a matching second never triggers.
- Second event: sec_l_d registers sec_l. prime bit resets to 0 and sets after the first clock. sec_evt = prime && (sec_l != sec_l_d).
- States are IDLE, RING and SNOOZE. Reset state is IDLE.
- IDLE: trig && alarm_en && adjust==0 moves to RING. On entry, ring_cnt=0 and snooze_cnt=0. trig with alarm_en=0 or adjust!=0 is dropped.
- RING: sec_evt increments ring_cnt. Exits, highest priority first:
  - key_stop or !alarm_en goes to IDLE.
  - key_snooze && snooze_cnt<MAX_SNOOZE goes to SNOOZE. snooze_cnt increments and snz_tmr loads SNOOZE_MIN*60.
  - ring_cnt reaching RING_SEC-1 on a sec_evt goes to IDLE (timeout).
- key_snooze with snooze_cnt==MAX_SNOOZE is ignored; the ring continues.
- SNOOZE: sec_evt decrements snz_tmr. Exits, highest priority first:
  - key_stop or !alarm_en goes to IDLE.
  - snz_tmr reaching 1 on a sec_evt goes to RING with ring_cnt=0. snooze_cnt is kept.
- trig in RING or SNOOZE is ignored. adjust changes after triggering do not affect the sequence.
- Leaving to IDLE clears snooze_cnt.
- LED: blink_cnt counts 0..BLINK_CYC-1 in RING. led toggles at wrap. blink_cnt and led are forced to 0 in any other state, and led restarts at 1 on RING entry.
- Widths: ring_cnt is $clog2(RING_SEC+1), snz_tmr is $clog2(SNOOZE_MIN*60+1), blink_cnt is $clog2(BLINK_CYC). No counter wraps unintentionally; all saturate by state exit.

## Timing
- All outputs are registered. Reset values: ring=0, snoozing=0, led=0, snooze_cnt=0, state IDLE, ring_cnt=0, snz_tmr=0, blink_cnt=0, match_d=1, prime=0.
- trig is sampled at edge N. ring, led and snooze_cnt reflect RING from cycle N+1.
- Key pulses act on the edge where they are sampled high. Outputs change the next cycle. Simultaneous key_stop and key_snooze resolve as stop.
- Timeout: ring drops one cycle after the RING_SEC-th sec_evt in RING.
- Snooze expiry: ring rises one cycle after the (SNOOZE_MIN*60)-th sec_evt in SNOOZE.
- Asserting s_rst_n low mid-ring clears all outputs asynchronously. After release, no trigger occurs until match next rises.

## Test plan
Bench parameters: RING_SEC=5, SNOOZE_MIN=1, MAX_SNOOZE=2, BLINK_CYC=4.
- Alarm 07:30, time steps 07:29:59 to 07:30:00, alarm_en=1, adjust=0 -> ring=1 next cycle, led toggles every 4 clk, snooze_cnt=0.
- Same with alarm_en=0, and separately with adjust=2'b01 -> ring stays 0 through 07:30:59.
- Ringing with no keys and 5 sec_l changes -> ring=0 one cycle after the 5th change, state IDLE, led=0.
- Ringing, key_snooze -> snoozing=1, snooze_cnt=1. After 60 sec_evt -> ring=1. key_snooze again -> snooze_cnt=2. After 60 sec_evt, ring=1 again. A third key_snooze is ignored (ring stays 1).
- Ringing, key_stop and key_snooze in the same cycle -> IDLE, snooze_cnt=0, no re-trigger while time remains 07:30:xx.
- Reset asserted during SNOOZE at 07:30:00, then released -> all outputs 0, no ring until the next 07:30:00 transition.

Source files
------------

// File: rtl/alarm_sched_if.sv
// Signal bundle between the alarm sequencer and the clock top level:
// running time, alarm time, user controls in; ring/snooze status out.
interface alarm_sched_if;
  logic [3:0] hour_h, hour_l, min_h, min_l, sec_h, sec_l;
  logic [3:0] alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l;
  logic       alarm_en;
  logic [1:0] adjust;
  logic       key_snooze;
  logic       key_stop;
  logic       ring;
  logic       snoozing;
  logic       led;
  logic [1:0] snooze_cnt;

  modport master (
    output hour_h, hour_l, min_h, min_l, sec_h, sec_l,
    output alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l,
    output alarm_en, adjust, key_snooze, key_stop,
    input  ring, snoozing, led, snooze_cnt
  );

  modport slave (
    input  hour_h, hour_l, min_h, min_l, sec_h, sec_l,
    input  alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l,
    input  alarm_en, adjust, key_snooze, key_stop,
    output ring, snoozing, led, snooze_cnt
  );
endinterface

// File: rtl/alarm_sched.sv
// Alarm ring/snooze sequencer: fires once per alarm minute, then walks
// IDLE/RING/SNOOZE from the snooze and stop keys with a blinking LED.
module alarm_sched #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int BLINK_CYC  = 12_500_000
) (
  input  logic        clk,
  input  logic        s_rst_n,
  alarm_sched_if.slave bus_if
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [RW-1:0] RING_LAST  = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNZ_LOAD   = SW'(SNOOZE_MIN * 60);
  localparam logic [SW-1:0] SNZ_LAST   = SW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
  localparam logic [1:0]    SNZ_MAX    = 2'(MAX_SNOOZE);

  // CLK_HZ only documents the clock; reject nonsensical parameter sets early
  if (CLK_HZ < 1 || MAX_SNOOZE < 1 || MAX_SNOOZE > 3) begin : g_param_check
    $error("alarm_sched: bad parameter set");
  end

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SW-1:0]   snz_tmr_q, snz_tmr_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [1:0]      snooze_cnt_q, snooze_cnt_d;
  logic            led_q, led_d;
  logic            ring_q, snoozing_q;
  logic            match_q, prime_q;
  logic [3:0]      sec_l_q;
  logic            match, trig, sec_evt;

  assign match = (bus_if.hour_h == bus_if.alarm_hour_h) &&
                 (bus_if.hour_l == bus_if.alarm_hour_l) &&
                 (bus_if.min_h  == bus_if.alarm_min_h)  &&
                 (bus_if.min_l  == bus_if.alarm_min_l)  &&
                 (bus_if.sec_h == 4'd0) && (bus_if.sec_l == 4'd0);

  // match_q resets high so a reset inside the alarm second cannot trigger
  assign trig    = match & ~match_q;
  assign sec_evt = prime_q && (bus_if.sec_l != sec_l_q);

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snz_tmr_d    = snz_tmr_q;
    snooze_cnt_d = snooze_cnt_q;
    blink_cnt_d  = '0;
    led_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig && bus_if.alarm_en && (bus_if.adjust == 2'b00)) begin
          state_d      = RING;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end
      end
      RING: begin
        if (bus_if.key_stop || !bus_if.alarm_en) begin
          state_d = IDLE;
        end else if (bus_if.key_snooze && (snooze_cnt_q < SNZ_MAX)) begin
          state_d      = SNOOZE;
          snooze_cnt_d = snooze_cnt_q + 2'd1;
          snz_tmr_d    = SNZ_LOAD;
        end else if (sec_evt) begin
          if (ring_cnt_q == RING_LAST) state_d = IDLE;
          else                         ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
      SNOOZE: begin
        if (bus_if.key_stop || !bus_if.alarm_en) begin
          state_d = IDLE;
        end else if (sec_evt) begin
          if (snz_tmr_q == SNZ_LAST) begin
            state_d    = RING;
            ring_cnt_d = '0;
          end else begin
            snz_tmr_d = snz_tmr_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) snooze_cnt_d = '0;

    // Every entry into RING restarts the blink phase with the LED lit
    if (state_d == RING) begin
      if (state_q != RING) begin
        blink_cnt_d = '0;
        led_d       = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        led_d       = ~led_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        led_d       = led_q;
      end
    end
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q      <= IDLE;
      ring_cnt_q   <= '0;
      snz_tmr_q    <= '0;
      blink_cnt_q  <= '0;
      snooze_cnt_q <= '0;
      led_q        <= 1'b0;
      ring_q       <= 1'b0;
      snoozing_q   <= 1'b0;
      match_q      <= 1'b1;
      prime_q      <= 1'b0;
      sec_l_q      <= '0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_tmr_q    <= snz_tmr_d;
      blink_cnt_q  <= blink_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      led_q        <= led_d;
      ring_q       <= (state_d == RING);
      snoozing_q   <= (state_d == SNOOZE);
      match_q      <= match;
      prime_q      <= 1'b1;
      sec_l_q      <= bus_if.sec_l;
    end
  end

  assign bus_if.ring       = ring_q;
  assign bus_if.snoozing   = snoozing_q;
  assign bus_if.led        = led_q;
  assign bus_if.snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_sched.sv
// Directed bench for alarm_sched: vector table for trigger/blink/timeout,
// hand sequences for blocked triggers, snooze limits, stop and reset.
module tb_alarm_sched;

  logic clk;
  logic s_rst_n;
  int   passed = 0;
  int   total  = 0;
  int   t      = 0;

  alarm_sched_if bus_if ();

  alarm_sched #(
    .CLK_HZ    (100),
    .RING_SEC  (5),
    .SNOOZE_MIN(1),
    .MAX_SNOOZE(2),
    .BLINK_CYC (4)
  ) dut (
    .clk    (clk),
    .s_rst_n(s_rst_n),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         hh, mm, ss;
    logic       en;
    logic [1:0] adj;
    logic       ring, snoozing, led;
    logic [1:0] scnt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    bus_if.hour_h = 4'(hh / 10);
    bus_if.hour_l = 4'(hh % 10);
    bus_if.min_h  = 4'(mm / 10);
    bus_if.min_l  = 4'(mm % 10);
    bus_if.sec_h  = 4'(ss / 10);
    bus_if.sec_l  = 4'(ss % 10);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the clock time by one second past 07:30:00 and take one clk
  task automatic adv();
    t++;
    set_time(7, 30 + t / 60, t % 60);
    tick();
  endtask

  task automatic fire();
    set_time(7, 29, 59);
    tick();
    t = 0;
    set_time(7, 30, 0);
    tick();
  endtask

  task automatic pulse_snooze();
    bus_if.key_snooze = 1'b1;
    tick();
    bus_if.key_snooze = 1'b0;
  endtask

  task automatic sweep_blocked(input logic en, input logic [1:0] adj, input string nm);
    bus_if.alarm_en = en;
    bus_if.adjust   = adj;
    set_time(7, 29, 59);
    tick();
    for (int s = 0; s < 60; s++) begin
      set_time(7, 30, s);
      tick();
      chk($sformatf("%s.ring@%0d", nm, s), int'(bus_if.ring), 0);
    end
    set_time(7, 31, 0);
    tick();
    bus_if.alarm_en = 1'b1;
    bus_if.adjust   = 2'b00;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{7, 29, 58, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{7, 29, 59, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{7, 30,  0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[3]  = '{7, 30,  0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[4]  = '{7, 30,  0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[5]  = '{7, 30,  0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[6]  = '{7, 30,  0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{7, 30,  0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{7, 30,  0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[9]  = '{7, 30,  0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{7, 30,  0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[11] = '{7, 30,  1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[12] = '{7, 30,  2, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[13] = '{7, 30,  3, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[14] = '{7, 30,  4, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[15] = '{7, 30,  5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[16] = '{7, 30,  6, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0};

    s_rst_n             = 1'b0;
    bus_if.alarm_hour_h = 4'd0;
    bus_if.alarm_hour_l = 4'd7;
    bus_if.alarm_min_h  = 4'd3;
    bus_if.alarm_min_l  = 4'd0;
    bus_if.alarm_en     = 1'b1;
    bus_if.adjust       = 2'b00;
    bus_if.key_snooze   = 1'b0;
    bus_if.key_stop     = 1'b0;
    set_time(7, 29, 58);
    tick();
    tick();
    chk("reset.ring", int'(bus_if.ring), 0);
    chk("reset.snoozing", int'(bus_if.snoozing), 0);
    chk("reset.led", int'(bus_if.led), 0);
    chk("reset.scnt", int'(bus_if.snooze_cnt), 0);
    @(negedge clk);
    s_rst_n = 1'b1;

    // Trigger, blink period and 5-second timeout
    for (int i = 0; i < 17; i++) begin
      set_time(vecs[i].hh, vecs[i].mm, vecs[i].ss);
      bus_if.alarm_en = vecs[i].en;
      bus_if.adjust   = vecs[i].adj;
      tick();
      $display("vec %0d %02d:%02d:%02d ring=%0d snz=%0d led=%0d scnt=%0d", i,
               vecs[i].hh, vecs[i].mm, vecs[i].ss, bus_if.ring, bus_if.snoozing,
               bus_if.led, bus_if.snooze_cnt);
      chk($sformatf("vec%0d.ring", i), int'(bus_if.ring), int'(vecs[i].ring));
      chk($sformatf("vec%0d.snoozing", i), int'(bus_if.snoozing), int'(vecs[i].snoozing));
      chk($sformatf("vec%0d.led", i), int'(bus_if.led), int'(vecs[i].led));
      chk($sformatf("vec%0d.scnt", i), int'(bus_if.snooze_cnt), int'(vecs[i].scnt));
    end

    sweep_blocked(1'b0, 2'b00, "disabled");
    sweep_blocked(1'b1, 2'b01, "adjust");

    // Two snoozes allowed, third ignored, then stop
    fire();
    chk("snz.fire.ring", int'(bus_if.ring), 1);
    pulse_snooze();
    chk("snz1.snoozing", int'(bus_if.snoozing), 1);
    chk("snz1.ring", int'(bus_if.ring), 0);
    chk("snz1.scnt", int'(bus_if.snooze_cnt), 1);
    chk("snz1.led", int'(bus_if.led), 0);
    repeat (59) adv();
    chk("snz1.59.snoozing", int'(bus_if.snoozing), 1);
    adv();
    chk("snz1.exp.ring", int'(bus_if.ring), 1);
    chk("snz1.exp.snoozing", int'(bus_if.snoozing), 0);
    chk("snz1.exp.scnt", int'(bus_if.snooze_cnt), 1);
    chk("snz1.exp.led", int'(bus_if.led), 1);
    pulse_snooze();
    chk("snz2.snoozing", int'(bus_if.snoozing), 1);
    chk("snz2.scnt", int'(bus_if.snooze_cnt), 2);
    repeat (59) adv();
    chk("snz2.59.snoozing", int'(bus_if.snoozing), 1);
    adv();
    chk("snz2.exp.ring", int'(bus_if.ring), 1);
    chk("snz2.exp.scnt", int'(bus_if.snooze_cnt), 2);
    pulse_snooze();
    chk("snz3.ring", int'(bus_if.ring), 1);
    chk("snz3.snoozing", int'(bus_if.snoozing), 0);
    chk("snz3.scnt", int'(bus_if.snooze_cnt), 2);
    bus_if.key_stop = 1'b1;
    tick();
    bus_if.key_stop = 1'b0;
    chk("stop.ring", int'(bus_if.ring), 0);
    chk("stop.scnt", int'(bus_if.snooze_cnt), 0);
    $display("snooze sequence done ring=%0d scnt=%0d", bus_if.ring, bus_if.snooze_cnt);

    // Simultaneous stop and snooze resolve as stop; no re-trigger in the minute
    fire();
    chk("both.fire.ring", int'(bus_if.ring), 1);
    bus_if.key_snooze = 1'b1;
    bus_if.key_stop   = 1'b1;
    tick();
    bus_if.key_snooze = 1'b0;
    bus_if.key_stop   = 1'b0;
    chk("both.ring", int'(bus_if.ring), 0);
    chk("both.snoozing", int'(bus_if.snoozing), 0);
    chk("both.scnt", int'(bus_if.snooze_cnt), 0);
    for (int s = 1; s < 60; s++) begin
      adv();
      chk($sformatf("both.noretrig@%0d", s), int'(bus_if.ring), 0);
    end

    // Asynchronous reset during SNOOZE in the alarm second
    fire();
    pulse_snooze();
    chk("rst.pre.snoozing", int'(bus_if.snoozing), 1);
    #3;
    s_rst_n = 1'b0;
    #1;
    chk("rst.async.snoozing", int'(bus_if.snoozing), 0);
    chk("rst.async.ring", int'(bus_if.ring), 0);
    chk("rst.async.led", int'(bus_if.led), 0);
    chk("rst.async.scnt", int'(bus_if.snooze_cnt), 0);
    @(negedge clk);
    s_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst.hold%0d.ring", k), int'(bus_if.ring), 0);
      chk($sformatf("rst.hold%0d.snoozing", k), int'(bus_if.snoozing), 0);
    end
    set_time(7, 30, 1);
    tick();
    chk("rst.sec1.ring", int'(bus_if.ring), 0);
    fire();
    chk("rst.refire.ring", int'(bus_if.ring), 1);
    chk("rst.refire.led", int'(bus_if.led), 1);
    $display("reset sequence done ring=%0d", bus_if.ring);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
